// File: rtl/wb_accel_pkg.sv
// wb_accel_pkg: shared FSM states, CSR word offsets and slot decode helper for the accelerator dispatcher
package wb_accel_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
   localparam logic [1:0] CSR_IRQ_STATUS = 2'd0;
   localparam logic [1:0] CSR_IRQ_ENABLE = 2'd1;
   localparam logic [1:0] CSR_TO_STATUS  = 2'd2;
   function automatic int unsigned slot_of(input logic [31:0] adr, input int lsb, input int w);
      return (adr >> lsb) & ((32'd1 << w) - 32'd1);
   endfunction
endpackage

// File: rtl/wb_accel_csr.sv
// wb_accel_csr: sticky maskable per-slot IRQ status, IRQ enable, timeout status and registered irq_o
//   clk, rst_sys_n      clock, async active-low reset
//   wr_i, off_i, wdat_i CSR write strobe, word offset, write data (slot bits only)
//   rdat_o              combinational read data for off_i
//   acc_irq_i           level irq lines from accelerators, edge-detected here
//   to_set_i, to_slot_i timeout event and the slot that timed out
//   irq_o               |(status & enable), registered
module wb_accel_csr
   import wb_accel_pkg::*;
#(
   parameter int NUM_ACCEL = 2,
   parameter int SLOT_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_sys_n,
   input  logic                 wr_i,
   input  logic [1:0]           off_i,
   input  logic [NUM_ACCEL-1:0] wdat_i,
   output logic [31:0]          rdat_o,
   input  logic [NUM_ACCEL-1:0] acc_irq_i,
   input  logic                 to_set_i,
   input  logic [SLOT_W-1:0]    to_slot_i,
   output logic                 irq_o
);
   logic [NUM_ACCEL-1:0] irq_prev_q, status_q, status_d, enable_q, enable_d;
   logic                 to_flag_q, to_flag_d, to_wr;
   logic [SLOT_W-1:0]    to_slot_q, to_slot_d;
   logic                 irq_q;
   always_comb begin
      to_wr     = wr_i && off_i == CSR_TO_STATUS;
      // a rising edge in the same cycle as a W1C keeps the bit set
      status_d  = (status_q & ~((wr_i && off_i == CSR_IRQ_STATUS) ? wdat_i : '0)) | (acc_irq_i & ~irq_prev_q);
      enable_d  = (wr_i && off_i == CSR_IRQ_ENABLE) ? wdat_i : enable_q;
      to_flag_d = to_set_i | (to_flag_q & ~to_wr);
      to_slot_d = to_set_i ? to_slot_i : to_wr ? '0 : to_slot_q;
      rdat_o    = off_i == CSR_IRQ_STATUS ? 32'(status_q) :
                  off_i == CSR_IRQ_ENABLE ? 32'(enable_q) :
                  off_i == CSR_TO_STATUS  ? {to_flag_q, {(31-SLOT_W){1'b0}}, to_slot_q} : '0;
   end
   always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         irq_prev_q <= '0;
         status_q   <= '0;
         enable_q   <= '0;
         to_flag_q  <= 1'b0;
         to_slot_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_prev_q <= acc_irq_i;
         status_q   <= status_d;
         enable_q   <= enable_d;
         to_flag_q  <= to_flag_d;
         to_slot_q  <= to_slot_d;
         irq_q      <= |(status_d & enable_d);
      end
   end
   assign irq_o = irq_q;
endmodule

// File: rtl/wb_accel_dispatch.sv
// wb_accel_dispatch: Wishbone slave that forwards NA wbm accesses to one of NUM_ACCEL accelerator slots
//   wbs_*      classic Wishbone slave from the network adapter (one-cycle ack/err)
//   acc_*      flat per-slot Wishbone master buses, slot s at [32s+:32] / [4s+:4] / [s]
//   acc_irq_i  level irq per slot; irq_o = |(IRQ_STATUS & IRQ_ENABLE), registered
//   slot field adr[SLOT_LSB+:SLOT_W]: all-ones selects the CSR window, >= NUM_ACCEL errors
module wb_accel_dispatch
   import wb_accel_pkg::*;
#(
   parameter int NUM_ACCEL = 2,
   parameter int SLOT_W    = 2,
   parameter int SLOT_LSB  = 12,
   parameter int TIMEOUT   = 1024
) (
   input  logic                    clk,
   input  logic                    rst_sys_n,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_we_i,
   output logic [31:0]             wbs_dat_o,
   output logic                    wbs_ack_o,
   output logic                    wbs_err_o,
   output logic [32*NUM_ACCEL-1:0] acc_adr_o,
   output logic [32*NUM_ACCEL-1:0] acc_dat_o,
   output logic [4*NUM_ACCEL-1:0]  acc_sel_o,
   output logic [NUM_ACCEL-1:0]    acc_cyc_o,
   output logic [NUM_ACCEL-1:0]    acc_stb_o,
   output logic [NUM_ACCEL-1:0]    acc_we_o,
   input  logic [32*NUM_ACCEL-1:0] acc_dat_i,
   input  logic [NUM_ACCEL-1:0]    acc_ack_i,
   input  logic [NUM_ACCEL-1:0]    acc_err_i,
   input  logic [NUM_ACCEL-1:0]    acc_irq_i,
   output logic                    irq_o
);
   localparam int                CNT_W     = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [SLOT_W-1:0] CSR_SLOT  = '1;
   localparam logic [SLOT_W-1:0] NUM_S     = SLOT_W'(NUM_ACCEL);
   localparam logic [31:0]       SLOT_MASK = ((32'd1 << SLOT_W) - 32'd1) << SLOT_LSB;
   state_t               state_q;
   logic [31:0]          adr_q, dat_q, rdat_q, hit_dat, csr_rdat;
   logic [3:0]           sel_q;
   logic                 we_q, ack_q, err_q;
   logic [SLOT_W-1:0]    slot_q, slot_in;
   logic [NUM_ACCEL-1:0] cyc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 req, csr_wr, to_hit, hit_ack, hit_err, to_set;
   always_comb begin
      slot_in = SLOT_W'(slot_of(wbs_adr_i, SLOT_LSB, SLOT_W));
      req     = state_q == IDLE && wbs_cyc_i && wbs_stb_i;
      csr_wr  = req && slot_in == CSR_SLOT && wbs_we_i;
      hit_ack = |(acc_ack_i & cyc_q);
      hit_err = |(acc_err_i & cyc_q);
      to_hit  = TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1);
      // abort, ack and accelerator err all take precedence over the timeout
      to_set  = state_q == ACTIVE && wbs_cyc_i && !hit_ack && !hit_err && to_hit;
      hit_dat = '0;
      for (int s = 0; s < NUM_ACCEL; s++) hit_dat |= acc_dat_i[32*s+:32] & {32{cyc_q[s]}};
   end
   always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         rdat_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         slot_q  <= '0;
         cyc_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               adr_q  <= wbs_adr_i & ~SLOT_MASK;
               dat_q  <= wbs_dat_i;
               sel_q  <= wbs_sel_i;
               we_q   <= wbs_we_i;
               slot_q <= slot_in;
               cnt_q  <= '0;
               if (slot_in == CSR_SLOT) begin
                  rdat_q  <= csr_rdat;
                  ack_q   <= 1'b1;
                  state_q <= RESP;
               end else if (slot_in >= NUM_S) begin
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cyc_q   <= NUM_ACCEL'(1) << slot_in;
                  state_q <= ACTIVE;
               end
            end
            ACTIVE: if (!wbs_cyc_i) begin
               cyc_q   <= '0;
               state_q <= IDLE;
            end else if (hit_ack) begin
               cyc_q   <= '0;
               rdat_q  <= hit_dat;
               ack_q   <= 1'b1;
               state_q <= RESP;
            end else if (hit_err || to_hit) begin
               cyc_q   <= '0;
               err_q   <= 1'b1;
               state_q <= RESP;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            RESP: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   wb_accel_csr #(.NUM_ACCEL(NUM_ACCEL), .SLOT_W(SLOT_W)) u_csr (
      .clk       (clk),
      .rst_sys_n (rst_sys_n),
      .wr_i      (csr_wr),
      .off_i     (wbs_adr_i[3:2]),
      .wdat_i    (wbs_dat_i[NUM_ACCEL-1:0]),
      .rdat_o    (csr_rdat),
      .acc_irq_i (acc_irq_i),
      .to_set_i  (to_set),
      .to_slot_i (slot_q),
      .irq_o     (irq_o)
   );
   assign wbs_dat_o = rdat_q;
   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;
   assign acc_adr_o = {NUM_ACCEL{adr_q}};
   assign acc_dat_o = {NUM_ACCEL{dat_q}};
   assign acc_sel_o = {NUM_ACCEL{sel_q}};
   assign acc_cyc_o = cyc_q;
   assign acc_stb_o = cyc_q;
   assign acc_we_o  = cyc_q & {NUM_ACCEL{we_q}};
endmodule

// File: tb/tb_wb_accel_dispatch.sv
// tb_wb_accel_dispatch: directed checks of slot dispatch, errors, timeout, CSRs, irq, abort and reset
module tb_wb_accel_dispatch;
   logic        clk = 1'b0;
   logic        rst_sys_n;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic [3:0]  wbs_sel_i;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o, wbs_err_o;
   logic [63:0] acc_adr_o, acc_dat_o, acc_dat_i;
   logic [7:0]  acc_sel_o;
   logic [1:0]  acc_cyc_o, acc_stb_o, acc_we_o, acc_ack_i, acc_err_i, acc_irq_i;
   logic        irq_o;
   int          n_chk = 0, n_pass = 0;
   logic [31:0] r_dat, r_fwd_adr, r_fwd_dat;
   logic [3:0]  r_fwd_sel;
   logic [1:0]  r_cyc_or, r_we_or;
   logic        r_ack, r_err, r_pulse2;
   int          r_lat, r_cyc_cnt;

   always #5 clk = ~clk;

   wb_accel_dispatch #(.NUM_ACCEL(2), .SLOT_W(2), .SLOT_LSB(12), .TIMEOUT(8)) dut (
      .clk(clk), .rst_sys_n(rst_sys_n),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
      .acc_adr_o(acc_adr_o), .acc_dat_o(acc_dat_o), .acc_sel_o(acc_sel_o),
      .acc_cyc_o(acc_cyc_o), .acc_stb_o(acc_stb_o), .acc_we_o(acc_we_o),
      .acc_dat_i(acc_dat_i), .acc_ack_i(acc_ack_i), .acc_err_i(acc_err_i),
      .acc_irq_i(acc_irq_i), .irq_o(irq_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // one Wishbone transfer starting at a negedge; the accelerator model acks
   // in its acc_lat-th cycle of seeing cyc (never when acc_lat < 0)
   task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                          input logic [3:0] sel, input int acc_lat, input logic [31:0] acc_rdat);
      r_lat = -1; r_cyc_cnt = 0; r_cyc_or = '0; r_we_or = '0;
      r_ack = 1'b0; r_err = 1'b0; r_dat = '0; r_pulse2 = 1'b0;
      r_fwd_adr = '0; r_fwd_dat = '0; r_fwd_sel = '0;
      wbs_adr_i = adr; wbs_dat_i = wdat; wbs_we_i = we; wbs_sel_i = sel;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (wbs_ack_o || wbs_err_o) begin
            r_ack = wbs_ack_o; r_err = wbs_err_o; r_dat = wbs_dat_o; r_lat = c;
            break;
         end
         if (acc_cyc_o != 2'b00) begin
            r_cyc_cnt++;
            r_cyc_or |= acc_cyc_o;
            r_we_or  |= acc_we_o;
            if (r_cyc_cnt == 1) begin
               r_fwd_adr = acc_cyc_o[1] ? acc_adr_o[63:32] : acc_adr_o[31:0];
               r_fwd_dat = acc_cyc_o[1] ? acc_dat_o[63:32] : acc_dat_o[31:0];
               r_fwd_sel = acc_cyc_o[1] ? acc_sel_o[7:4]   : acc_sel_o[3:0];
            end
            acc_ack_i = (r_cyc_cnt == acc_lat) ? acc_cyc_o : 2'b00;
            acc_dat_i = acc_cyc_o[1] ? {acc_rdat, 32'hBAD0BAD0} : {32'hBAD0BAD0, acc_rdat};
         end else acc_ack_i = 2'b00;
      end
      acc_ack_i = 2'b00;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      @(negedge clk);
      r_pulse2 = wbs_ack_o | wbs_err_o;
   endtask

   initial begin
      rst_sys_n = 1'b0;
      wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      acc_dat_i = '0; acc_ack_i = '0; acc_err_i = '0; acc_irq_i = '0;
      repeat (2) @(negedge clk);
      check("rst_ack_err", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_acc_cyc", {26'd0, acc_cyc_o, acc_stb_o, acc_we_o}, 32'd0);
      check("rst_acc_adr", acc_adr_o[31:0] | acc_adr_o[63:32], 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      rst_sys_n = 1'b1;
      @(negedge clk);

      // write 0xDEADBEEF to slot 1, accelerator acks in its 3rd cycle
      wb_xfer(32'h0000_1024, 32'hDEADBEEF, 1'b1, 4'b0110, 3, 32'h0);
      check("wr1_ack", {30'd0, r_ack, r_err}, 32'd2);
      check("wr1_lat", r_lat, 32'd4);
      check("wr1_cyc_cnt", r_cyc_cnt, 32'd3);
      check("wr1_cyc_slot", {30'd0, r_cyc_or}, 32'd2);
      check("wr1_we_slot", {30'd0, r_we_or}, 32'd2);
      check("wr1_fwd_dat", r_fwd_dat, 32'hDEADBEEF);
      check("wr1_fwd_sel", {28'd0, r_fwd_sel}, 32'd6);
      check("wr1_fwd_adr", r_fwd_adr, 32'h0000_0024);
      check("wr1_pulse", {31'd0, r_pulse2}, 32'd0);

      // read slot 0, accelerator returns 0x12345678 after 1 cycle
      wb_xfer(32'h0000_0010, 32'h0, 1'b0, 4'hF, 1, 32'h12345678);
      check("rd0_ack", {30'd0, r_ack, r_err}, 32'd2);
      check("rd0_dat", r_dat, 32'h12345678);
      check("rd0_lat", r_lat, 32'd2);
      check("rd0_cyc_slot", {30'd0, r_cyc_or}, 32'd1);
      check("rd0_we", {30'd0, r_we_or}, 32'd0);

      // unmapped slot 2
      wb_xfer(32'h0000_2000, 32'h0, 1'b0, 4'hF, 1, 32'h0);
      check("unm_err", {30'd0, r_ack, r_err}, 32'd1);
      check("unm_lat", r_lat, 32'd1);
      check("unm_cyc_cnt", r_cyc_cnt, 32'd0);
      check("unm_pulse", {31'd0, r_pulse2}, 32'd0);

      // timeout on slot 1 (TIMEOUT=8)
      wb_xfer(32'h0000_1000, 32'h0, 1'b0, 4'hF, -1, 32'h0);
      check("to_err", {30'd0, r_ack, r_err}, 32'd1);
      check("to_lat", r_lat, 32'd9);
      check("to_cyc_cnt", r_cyc_cnt, 32'd8);
      wb_xfer(32'h0000_3008, 32'h0, 1'b0, 4'hF, 0, 32'h0);
      check("to_status", r_dat, 32'h8000_0001);
      check("csr_lat", r_lat, 32'd1);
      wb_xfer(32'h0000_3008, 32'h0, 1'b1, 4'hF, 0, 32'h0);
      wb_xfer(32'h0000_3008, 32'h0, 1'b0, 4'hF, 0, 32'h0);
      check("to_status_clr", r_dat, 32'h0);
      wb_xfer(32'h0000_300C, 32'h0, 1'b0, 4'hF, 0, 32'h0);
      check("csr_rsvd", {r_dat[29:0], r_ack, r_err}, 32'd2);

      // irq: enable slot 1, rising edge, W1C vs simultaneous edge, later W1C
      wb_xfer(32'h0000_3004, 32'h2, 1'b1, 4'hF, 0, 32'h0);
      acc_irq_i = 2'b10;
      repeat (2) @(negedge clk);
      check("irq_set", {31'd0, irq_o}, 32'd1);
      wb_xfer(32'h0000_3000, 32'h0, 1'b0, 4'hF, 0, 32'h0);
      check("irq_status", r_dat, 32'h2);
      acc_irq_i = 2'b00;
      @(negedge clk);
      acc_irq_i = 2'b10;
      wb_xfer(32'h0000_3000, 32'h2, 1'b1, 4'hF, 0, 32'h0);
      wb_xfer(32'h0000_3000, 32'h0, 1'b0, 4'hF, 0, 32'h0);
      check("w1c_vs_edge", r_dat, 32'h2);
      check("irq_kept", {31'd0, irq_o}, 32'd1);
      wb_xfer(32'h0000_3000, 32'h2, 1'b1, 4'hF, 0, 32'h0);
      check("irq_clr", {31'd0, irq_o}, 32'd0);
      wb_xfer(32'h0000_3000, 32'h0, 1'b0, 4'hF, 0, 32'h0);
      check("irq_status_clr", r_dat, 32'h0);
      acc_irq_i = 2'b00;

      // abort: drop cyc while slot 0 is active
      wbs_adr_i = 32'h0000_0040; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      @(negedge clk);
      check("abt_cyc_on", {30'd0, acc_cyc_o}, 32'd1);
      @(negedge clk);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(negedge clk);
      check("abt_cyc_off", {30'd0, acc_cyc_o}, 32'd0);
      check("abt_no_resp", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
      @(negedge clk);
      check("abt_no_resp2", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);

      // reset in the middle of a slot 1 access, with irq enabled beforehand
      wb_xfer(32'h0000_3004, 32'h3, 1'b1, 4'hF, 0, 32'h0);
      wbs_adr_i = 32'h0000_1080; wbs_dat_i = 32'h55AA55AA; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (2) @(negedge clk);
      check("rstm_cyc_on", {30'd0, acc_cyc_o}, 32'd2);
      rst_sys_n = 1'b0;
      #1;
      check("rstm_acc", {26'd0, acc_cyc_o, acc_stb_o, acc_we_o}, 32'd0);
      check("rstm_adr_dat", acc_adr_o[63:32] | acc_dat_o[63:32], 32'd0);
      check("rstm_resp", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_sys_n = 1'b1;
      @(negedge clk);
      check("rstm_no_resp", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
      wb_xfer(32'h0000_0000, 32'h0, 1'b0, 4'hF, 2, 32'hCAFE0001);
      check("post_rst_dat", r_dat, 32'hCAFE0001);
      check("post_rst_lat", r_lat, 32'd3);
      wb_xfer(32'h0000_3004, 32'h0, 1'b0, 4'hF, 0, 32'h0);
      check("post_rst_en", r_dat, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
